// File: rtl/dmx_frame_buffer_if.sv
// Slot-stream write side and committed-frame read side of the DMX frame buffer.
// master drives slots and read addresses; slave is the buffer itself.
interface dmx_frame_buffer_if #(
    parameter int MAX_CHANNEL_BITS = 8
);
    localparam int AW = MAX_CHANNEL_BITS + 1;

    logic [7:0]    data;
    logic [AW-1:0] channel;
    logic          write_strobe;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_valid;
    logic          frame_swap;
    logic [AW-1:0] frame_len;

    modport master (
        output data, channel, write_strobe, rd_addr,
        input  rd_data, frame_valid, frame_swap, frame_len
    );

    modport slave (
        input  data, channel, write_strobe, rd_addr,
        output rd_data, frame_valid, frame_swap, frame_len
    );
endinterface

// File: rtl/dmx_frame_buffer.sv
// Ping-pong DMX frame store; commits on break/start code, last channel or idle timeout. DMX_FB_CLAMP_EN zeroes reads past frame_len.
// Latency: rd_data 1 cycle after rd_addr; commit visible the cycle after the deciding strobe/timeout.
// Backpressure: none; every write_strobe is consumed in the cycle it is presented.
module dmx_frame_buffer #(
    parameter int         MAX_CHANNEL_BITS = 8,
    parameter logic [7:0] START_CODE       = 8'h00,
    parameter int         FRAME_TIMEOUT    = 24000
) (
    input logic               clock,
    input logic               reset,
    dmx_frame_buffer_if.slave bus
);
    localparam int AW    = MAX_CHANNEL_BITS + 1;
    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(FRAME_TIMEOUT + 1);

    localparam logic [AW-1:0] LAST_CH = '1;
    localparam logic [TW-1:0] TMAX    = TW'(FRAME_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        SKIP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    mem [0:2*DEPTH-1];
    logic          active_bank;
    logic [AW-1:0] wr_len;
    logic [AW-1:0] len_upd;
    logic [TW-1:0] timer;
    logic          commit;
    logic          mem_we;
    logic          wr_bank;
    logic [AW:0]   wr_addr;
    logic [AW:0]   rd_ptr;
    logic [7:0]    rd_word;

    logic strobe_ch0;
    logic strobe_chk;
    logic is_start;
    logic timeout;
    logic has_data;
    logic last_ch;

    assign strobe_ch0 = bus.write_strobe && (bus.channel == '0);
    assign strobe_chk = bus.write_strobe && (bus.channel != '0);
    assign is_start   = (bus.data == START_CODE);
    assign timeout    = (timer == TMAX);
    assign has_data   = (wr_len != '0);
    assign last_ch    = (bus.channel == LAST_CH);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a strobe always wins over a same-cycle timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, SKIP: begin
                if (strobe_ch0) state_nxt = is_start ? RECV : SKIP;
            end
            RECV: begin
                if (strobe_ch0)                state_nxt = is_start ? RECV : SKIP;
                else if (strobe_chk && last_ch) state_nxt = IDLE;
                else if (!bus.write_strobe && timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: commit decision and RAM write enable
    always_comb begin
        commit = 1'b0;
        mem_we = 1'b0;
        case (state)
            IDLE, SKIP: begin
                mem_we = strobe_ch0;
            end
            RECV: begin
                mem_we = bus.write_strobe;
                if (strobe_ch0)                       commit = has_data;
                else if (strobe_chk && last_ch)       commit = 1'b1;
                else if (!bus.write_strobe && timeout) commit = has_data;
            end
            default: begin
                commit = 1'b0;
                mem_we = 1'b0;
            end
        endcase
    end

    assign len_upd = (state == RECV && strobe_chk && bus.channel > wr_len) ? bus.channel : wr_len;

    // A break that commits writes the new slot 0 into the bank being released;
    // the last-channel slot still belongs to the frame being committed.
    assign wr_bank = (commit && strobe_ch0) ? active_bank : ~active_bank;
    assign wr_addr = {wr_bank, bus.channel};
    assign rd_ptr  = {active_bank, bus.rd_addr};
    assign rd_word = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (mem_we) mem[wr_addr] <= bus.data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_len <= '0;
            timer  <= '0;
        end else begin
            wr_len <= strobe_ch0 ? '0 : len_upd;
            if (bus.write_strobe || state != RECV) timer <= '0;
            else if (!timeout)                     timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_bank     <= 1'b0;
            bus.frame_len   <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_swap  <= 1'b0;
        end else begin
            bus.frame_swap <= commit;
            if (commit) begin
                active_bank     <= ~active_bank;
                bus.frame_len   <= len_upd;
                bus.frame_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.rd_data <= 8'h00;
        end else begin
`ifdef DMX_FB_CLAMP_EN
            bus.rd_data <= (!bus.frame_valid || bus.rd_addr > bus.frame_len) ? 8'h00 : rd_word;
`else
            bus.rd_data <= rd_word;
`endif
        end
    end
endmodule

// File: tb/tb_dmx_frame_buffer.sv
// Scoreboard bench for dmx_frame_buffer: stimulus queues expected swaps/reads, a negedge monitor checks them.
module tb_dmx_frame_buffer;
    localparam int MCB = 8;
    localparam int AW  = MCB + 1;
    localparam int FT  = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dmx_frame_buffer_if #(.MAX_CHANNEL_BITS(MCB)) bus ();

    dmx_frame_buffer #(
        .MAX_CHANNEL_BITS(MCB),
        .START_CODE      (8'h00),
        .FRAME_TIMEOUT   (FT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int len;
        int cyc;
    } swap_t;

    swap_t      swq[$];
    logic [7:0] rdq[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         last_p   = 0;
    logic       rd_chk   = 1'b0;
    logic       rd_chk_d = 1'b0;
    logic [AW-1:0] rd_addr_d = '0;
    swap_t      se;
    logic [7:0] re;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        cyc       <= cyc + 1;
        rd_chk_d  <= rd_chk;
        rd_addr_d <= bus.rd_addr;
    end

    // Monitor: pops an expectation whenever the DUT presents a swap or a read result
    always @(negedge clock) begin
        if (reset && bus.frame_swap) begin
            if (swq.size() == 0) begin
                chk("swap_pending", swq.size(), 1);
            end else begin
                se = swq.pop_front();
                chk("swap_len", bus.frame_len, se.len);
                chk("swap_cycle", cyc, se.cyc);
                chk("swap_valid", bus.frame_valid, 1);
            end
        end
        if (rd_chk_d) begin
            if (rdq.size() == 0) begin
                chk("rd_pending", rdq.size(), 1);
            end else begin
                re = rdq.pop_front();
                chk($sformatf("rd_data@%0d", rd_addr_d), bus.rd_data, re);
            end
        end
    end

    task automatic put(input int ch, input logic [7:0] d);
        @(negedge clock);
        bus.channel      = AW'(ch);
        bus.data         = d;
        bus.write_strobe = 1'b1;
        last_p           = cyc + 1;
        @(posedge clock);
        #1 bus.write_strobe = 1'b0;
    endtask

    task automatic rd(input int a, input logic [7:0] e);
        @(negedge clock);
        bus.rd_addr = AW'(a);
        rd_chk      = 1'b1;
        rdq.push_back(e);
        @(posedge clock);
        #1 rd_chk = 1'b0;
    endtask

    task automatic exp_swap(input int len, input int c);
        swq.push_back('{len: len, cyc: c});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data         = 8'h00;
        bus.channel      = '0;
        bus.write_strobe = 1'b0;
        bus.rd_addr      = '0;
        #2 reset = 1'b0;
        idle(3);
        chk("reset_rd_data", bus.rd_data, 0);
        chk("reset_frame_valid", bus.frame_valid, 0);
        chk("reset_frame_swap", bus.frame_swap, 0);
        chk("reset_frame_len", bus.frame_len, 0);
        @(negedge clock);
        reset = 1'b1;

        // Basic frame committed by the next break
        put(0, 8'h00); put(1, 8'h11); put(2, 8'h22); put(3, 8'h33);
        put(0, 8'h00); exp_swap(3, last_p);
        rd(2, 8'h22); rd(1, 8'h11); rd(0, 8'h00);

        // Non-dimmer start code: frame is skipped, old frame still readable
        put(0, 8'hCC); put(1, 8'h55); put(0, 8'h00);
        idle(2);
        rd(1, 8'h11);

        // Full universe commits on channel 511 without a break
        for (int k = 1; k < 512; k++) put(k, 8'(k));
        exp_swap(511, last_p);
        rd(300, 8'h2C); rd(511, 8'hFF); rd(10, 8'h0A); rd(0, 8'h00);

        // Frame ending at channel 10, then a 3-channel frame in the other bank
        put(0, 8'h00); put(10, 8'hA5);
        put(0, 8'h00); exp_swap(10, last_p);
        rd(10, 8'hA5);
        put(1, 8'h01); put(2, 8'h02); put(3, 8'h03);
        put(0, 8'h00); exp_swap(3, last_p);
`ifdef DMX_FB_CLAMP_EN
        rd(10, 8'h00);
`else
        rd(10, 8'h0A);
`endif
        rd(3, 8'h03); rd(0, 8'h00);

        // Timeout commit: decided when the timer hits FT, pulse registered one cycle later
        put(1, 8'h51); put(2, 8'h52); put(3, 8'h53); put(4, 8'h54); put(5, 8'h55);
        exp_swap(5, last_p + FT + 1);
        idle(FT + 10);
        rd(5, 8'h55);
`ifdef DMX_FB_CLAMP_EN
        rd(10, 8'h00);
`else
        rd(10, 8'hA5);
`endif
        // Start code alone then silence: no commit
        put(0, 8'h00);
        idle(FT + 10);
        rd(5, 8'h55);

        // Reset mid-frame clears outputs at once and discards the partial frame
        put(0, 8'h00); put(1, 8'h77); put(2, 8'h88);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midreset_rd_data", bus.rd_data, 0);
        chk("midreset_frame_valid", bus.frame_valid, 0);
        chk("midreset_frame_swap", bus.frame_swap, 0);
        chk("midreset_frame_len", bus.frame_len, 0);
        idle(2);
        reset = 1'b1;
        idle(FT + 10);
        chk("postreset_frame_valid", bus.frame_valid, 0);
        chk("postreset_frame_len", bus.frame_len, 0);

        idle(3);
        chk("swap_queue_drained", swq.size(), 0);
        chk("rd_queue_drained", rdq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
